// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the byte-serial add/subtract sequencer.
//   BYTE_W                    width of the shared adder datapath
//   ST_IDLE/ST_RUN/ST_DONE    sequencer state encoding
package alu_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/adder_seq_ctrl_adder.sv
// Adder_8bit: the shared byte-wide adder the sequencer time-multiplexes.
//   a, b   in   8   addends
//   cin    in   1   carry in
//   sum    out  8   a + b + cin (mod 256)
//   cout   out  1   carry out of bit 7
module Adder_8bit
    import alu_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WORDS*8-bit add/subtract done one byte per clock on a single
// 8-bit adder, LSB byte first, with the carry chained through a register.
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    request handshake (op_sub, cin, op_a, op_b)
//   out_valid/out_ready  result handshake (result, cout, ovf)
//   busy                 high whenever the sequencer is not idle
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// RUN   | one byte per edge through the shared adder, idx = current byte
// DONE  | result held with out_valid=1 until out_ready
module adder_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op_sub,
    input  logic                     cin,
    input  logic [BYTE_W*WORDS-1:0]  op_a,
    input  logic [BYTE_W*WORDS-1:0]  op_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*WORDS-1:0]  result,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy
);

    localparam int N     = BYTE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N-1:0]      a_q, b_q, result_q;
    logic              carry_q, cout_q, ovf_q;
    logic              in_ready_q, out_valid_q, busy_q;

    logic [BYTE_W-1:0] a_byte, b_byte, sum_byte;
    logic              add_cout, ovf_d;

    assign a_byte = a_q[BYTE_W*idx_q +: BYTE_W];
    assign b_byte = b_q[BYTE_W*idx_q +: BYTE_W];
    assign idx_d  = idx_q + IDX_W'(1);

    // Signed overflow only matters on the top byte: operands share a sign
    // and the sum sign differs. b_q is already inverted for subtract.
    assign ovf_d = (a_byte[BYTE_W-1] ~^ b_byte[BYTE_W-1]) &
                   (a_byte[BYTE_W-1] ^ sum_byte[BYTE_W-1]);

    Adder_8bit u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (sum_byte),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= op_a;
                        b_q        <= op_b ^ {N{op_sub}};
                        // Subtract is A + ~B + 1, so cin is overridden.
                        carry_q    <= op_sub | cin;
                        idx_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    result_q[BYTE_W*idx_q +: BYTE_W] <= sum_byte;
                    carry_q <= add_cout;
                    if (idx_q == IDX_LAST) begin
                        cout_q      <= add_cout;
                        ovf_q       <= ovf_d;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule
